gcd_engine: RTL and testbench
=============================

Name: gcd_engine

Overview:
Parametrised successor to the fixed 16-bit subtract-only GCD unit. It loads both operands in parallel through a valid/ready handshake and computes the GCD iteratively. Selectable modes are repeated subtraction or binary (Stein) GCD. It reports the result, the iteration count and a zero-operand flag through a second valid/ready handshake. It sits between an operand producer and a result consumer as a self-contained datapath plus controller.

Parameters:
WIDTH, 16, operand and result width in bits (>=2)
MODE, 0, algorithm select: 0 = repeated subtraction, 1 = binary (Stein)
CNT_W, WIDTH+1, width of iteration counter output

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand pair a_in/b_in valid
in_ready  output  1  engine can accept operands
a_in  input  WIDTH  operand A (unsigned)
b_in  input  WIDTH  operand B (unsigned)
out_valid  output  1  result valid, held until out_ready
out_ready  input  1  consumer accepts result
gcd_out  output  WIDTH  GCD result
cycles  output  CNT_W  number of CALC cycles spent, saturating
err_zero  output  1  both operands were zero (gcd_out = 0)

Behaviour:
- Reset (async, rst=1): state IDLE, in_ready=1, out_valid=0, gcd_out=0, cycles=0, err_zero=0. Internal A, B and shift count k are cleared. Reset mid-CALC or mid-DONE aborts the operation and the result is lost.
- States: IDLE, CALC, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch A=a_in, B=b_in, k=0, cycles=0.
  - If A==0 or B==0, go directly to DONE with gcd_out = A|B and err_zero = (A==0 && B==0).
  - Otherwise go to CALC.
- CALC: in_ready=0. Each cycle increments cycles (saturates at all-ones) and performs one step.
  - MODE 0:
    - A==B: gcd_out=A, go to DONE.
    - A>B: A<=A-B.
    - otherwise: B<=B-A.
  - MODE 1, checks in priority order:
    - A==B: gcd_out = A<<k, truncated to WIDTH (cannot overflow because the true GCD <= min operand), go to DONE.
    - Both even: A>>=1, B>>=1, k++.
    - A even: A>>=1.
    - B even: B>>=1.
    - Both odd: larger <= larger - smaller.
  - k width is clog2(WIDTH)+1.
- DONE: out_valid=1. gcd_out, cycles and err_zero are held stable while out_ready=0. On out_ready, go to IDLE; out_valid drops next cycle.
- Latency, accept edge to out_valid: 1 cycle for zero operands, otherwise N+1 cycles, where N = number of CALC cycles (reported in cycles).
- in_ready is 1 only in IDLE, so no overlap between result hold and new accept. in_valid is ignored outside IDLE.
- Outputs other than in_ready and out_valid are registered.
- All arithmetic is unsigned WIDTH-bit. Subtraction never underflows because the larger operand is always reduced.

Decomposition:
- Package gcd_pkg holds:
  - state enum {IDLE, CALC, DONE};
  - MODE_SUB=0, MODE_BIN=1;
  - a clog2 helper for the k width.
- One natural sub-module, gcd_step (combinational). Inputs: A, B, k, mode. Outputs: next A/B/k and eq. The gcd_engine FSM instantiates it, and gcd_step is unit-testable alone.

Test Plan:
1. MODE0, WIDTH16: a=12, b=18 -> out_valid 4 cycles after accept, gcd_out=6, cycles=3, err_zero=0.
2. MODE1, WIDTH16: a=12, b=18 -> gcd_out=6, cycles=5. Also a=48, b=180 -> gcd_out=12 with identical result in MODE0.
3. Zero operands: (0,25) -> gcd_out=25; (0,0) -> gcd_out=0, err_zero=1. Both give cycles=0 and out_valid one cycle after accept.
4. Backpressure: hold out_ready=0 for 10 cycles after out_valid -> outputs stable and in_ready=0 throughout. Pulse out_ready -> IDLE, next pair accepted.
5. Reset mid-CALC: a=65535, b=1 in MODE0, assert rst after 100 cycles -> immediate in_ready=1, out_valid=0, cycles=0. A fresh (9,6) then yields gcd_out=3.
6. Width/saturation: WIDTH=8, CNT_W=4, MODE0, a=255, b=1 -> gcd_out=1, cycles saturates at 15.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD engine and its step datapath.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MODE_SUB = 0;
    localparam int MODE_BIN = 1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/gcd_step.sv
// One combinational GCD iteration: subtract-only, or binary (Stein) when i_mode is set.
module gcd_step
    import gcd_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int KW    = clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [KW-1:0]    i_k,
    input  logic             i_mode,
    output logic [WIDTH-1:0] o_a,
    output logic [WIDTH-1:0] o_b,
    output logic [KW-1:0]    o_k,
    output logic             o_eq
);

    always_comb begin
        o_a  = i_a;
        o_b  = i_b;
        o_k  = i_k;
        o_eq = (i_a == i_b);
        if (!o_eq) begin
            if (i_mode) begin
                // Common factors of two are stripped into k and restored at the end
                if (!i_a[0] && !i_b[0]) begin
                    o_a = i_a >> 1;
                    o_b = i_b >> 1;
                    o_k = i_k + KW'(1);
                end else if (!i_a[0]) begin
                    o_a = i_a >> 1;
                end else if (!i_b[0]) begin
                    o_b = i_b >> 1;
                end else if (i_a > i_b) begin
                    o_a = i_a - i_b;
                end else begin
                    o_b = i_b - i_a;
                end
            end else begin
                if (i_a > i_b) begin
                    o_a = i_a - i_b;
                end else begin
                    o_b = i_b - i_a;
                end
            end
        end
    end

endmodule

// File: rtl/gcd_engine.sv
// Iterative GCD engine with valid/ready operand intake and held result output.
//   state | meaning
//   IDLE  | waiting for an operand pair (in_ready=1)
//   CALC  | one gcd_step per cycle until A==B
//   DONE  | result presented (out_valid=1) until out_ready
module gcd_engine
    import gcd_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int MODE  = 0,
    parameter int CNT_W = WIDTH + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] gcd_out,
    output logic [CNT_W-1:0] cycles,
    output logic             err_zero
);

    localparam int KW = clog2(WIDTH) + 1;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [KW-1:0]    r_k;
    logic [WIDTH-1:0] r_gcd;
    logic [CNT_W-1:0] r_cycles;
    logic             r_err;

    logic [WIDTH-1:0] w_a_next;
    logic [WIDTH-1:0] w_b_next;
    logic [KW-1:0]    w_k_next;
    logic             w_eq;
    logic             w_mode;
    logic             w_zero_in;

    assign w_mode    = (MODE == MODE_BIN);
    assign w_zero_in = (a_in == '0) || (b_in == '0);

    gcd_step #(
        .WIDTH (WIDTH),
        .KW    (KW)
    ) u_step (
        .i_a    (r_a),
        .i_b    (r_b),
        .i_k    (r_k),
        .i_mode (w_mode),
        .o_a    (w_a_next),
        .o_b    (w_b_next),
        .o_k    (w_k_next),
        .o_eq   (w_eq)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_state_next = w_zero_in ? DONE : CALC;
                end
            end
            CALC: begin
                if (w_eq) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_k      <= '0;
            r_gcd    <= '0;
            r_cycles <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a      <= a_in;
                        r_b      <= b_in;
                        r_k      <= '0;
                        r_cycles <= '0;
                        r_err    <= (a_in == '0) && (b_in == '0);
                        if (w_zero_in) begin
                            r_gcd <= a_in | b_in;
                        end
                    end
                end
                CALC: begin
                    if (r_cycles != '1) begin
                        r_cycles <= r_cycles + CNT_W'(1);
                    end
                    r_a <= w_a_next;
                    r_b <= w_b_next;
                    r_k <= w_k_next;
                    // k is always zero in subtract mode, so the shift is harmless there
                    if (w_eq) begin
                        r_gcd <= r_a << r_k;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign gcd_out   = r_gcd;
    assign cycles    = r_cycles;
    assign err_zero  = r_err;

endmodule

// File: tb/tb_gcd_engine.sv
// Scoreboard bench: three engine configurations, directed vectors, monitor-side checking.
module tb_gcd_engine;

    typedef struct {
        int unsigned gcd;
        int unsigned cyc;
        bit          err;
        int          lat;
    } exp_t;

    exp_t q[3][$];

    logic        clk;
    logic        rst;
    logic [2:0]  iv;
    logic [2:0]  orr;
    logic [15:0] a_i [3];
    logic [15:0] b_i [3];

    wire  [2:0]  ir;
    wire  [2:0]  ov;
    wire  [2:0]  ez;
    wire  [15:0] g0;
    wire  [15:0] g1;
    wire  [7:0]  g2;
    wire  [16:0] c0;
    wire  [16:0] c1;
    wire  [3:0]  c2;

    int checks;
    int failures;
    int cyc;
    int acc_cyc [3];

    gcd_engine #(.WIDTH(16), .MODE(0)) d0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .a_in(a_i[0]), .b_in(b_i[0]), .out_valid(ov[0]), .out_ready(orr[0]),
        .gcd_out(g0), .cycles(c0), .err_zero(ez[0])
    );

    gcd_engine #(.WIDTH(16), .MODE(1)) d1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .a_in(a_i[1]), .b_in(b_i[1]), .out_valid(ov[1]), .out_ready(orr[1]),
        .gcd_out(g1), .cycles(c1), .err_zero(ez[1])
    );

    gcd_engine #(.WIDTH(8), .MODE(0), .CNT_W(4)) d2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .a_in(a_i[2][7:0]), .b_in(b_i[2][7:0]), .out_valid(ov[2]), .out_ready(orr[2]),
        .gcd_out(g2), .cycles(c2), .err_zero(ez[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int idx, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d: got %0d expected %0d (t=%0t)", name, idx, act, exp, $time);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_mon
        int unsigned mg;
        int unsigned mc;
        int          rise_lat;
        bit          prev_ov;
        exp_t        e;
        always @(negedge clk) begin
            mg = (gi == 0) ? 32'(g0) : (gi == 1) ? 32'(g1) : 32'(g2);
            mc = (gi == 0) ? 32'(c0) : (gi == 1) ? 32'(c1) : 32'(c2);
            if (rst) begin
                prev_ov = 1'b0;
            end else begin
                if (ov[gi] && !prev_ov) rise_lat = cyc - acc_cyc[gi] + 1;
                prev_ov = ov[gi];
                if (ov[gi] && orr[gi]) begin
                    if (q[gi].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_result dut%0d: got gcd %0d with no expectation queued", gi, mg);
                    end else begin
                        e = q[gi].pop_front();
                        check("gcd_out", gi, mg, e.gcd);
                        check("cycles", gi, mc, e.cyc);
                        check("err_zero", gi, 32'(ez[gi]), 32'(e.err));
                        check("latency", gi, rise_lat, e.lat);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int idx, input int unsigned a, input int unsigned b,
                        input int unsigned eg, input int unsigned ec, input bit ee,
                        input int el, input bit hold);
        int n;
        n = 0;
        while (!ir[idx] && n < 3000) begin tick(); n++; end
        if (!ir[idx]) begin
            checks++; failures++;
            $display("FAIL ready_timeout dut%0d: in_ready got 0 expected 1", idx);
        end
        q[idx].push_back('{gcd: eg, cyc: ec, err: ee, lat: el});
        a_i[idx] = 16'(a);
        b_i[idx] = 16'(b);
        orr[idx] = !hold;
        iv[idx]  = 1'b1;
        tick();
        iv[idx] = 1'b0;
        acc_cyc[idx] = cyc;
        if (hold) begin
            n = 0;
            while (!ov[idx] && n < 3000) begin tick(); n++; end
            for (int i = 0; i < 10; i++) begin
                tick();
                check("hold_gcd", idx, 32'(g0), eg);
                check("hold_cycles", idx, 32'(c0), ec);
                check("hold_err", idx, 32'(ez[idx]), 32'(ee));
                check("hold_in_ready", idx, 32'(ir[idx]), 0);
                check("hold_out_valid", idx, 32'(ov[idx]), 1);
            end
            orr[idx] = 1'b1;
        end
        n = 0;
        while (q[idx].size() != 0 && n < 3000) begin tick(); n++; end
        if (q[idx].size() != 0) begin
            checks++; failures++;
            $display("FAIL result_timeout dut%0d: pending %0d expected 0", idx, q[idx].size());
            q[idx].delete();
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        iv       = 3'b000;
        orr      = 3'b111;
        for (int i = 0; i < 3; i++) begin
            a_i[i]     = '0;
            b_i[i]     = '0;
            acc_cyc[i] = 0;
        end
        tick();
        tick();
        check("rst_in_ready", 0, 32'(ir), 7);
        check("rst_out_valid", 0, 32'(ov), 0);
        check("rst_gcd", 0, 32'(g0), 0);
        check("rst_cycles", 0, 32'(c0), 0);
        check("rst_err", 0, 32'(ez), 0);
        rst = 1'b0;
        tick();

        send(0, 12, 18, 6, 3, 0, 4, 0);
        send(1, 12, 18, 6, 5, 0, 6, 0);
        send(1, 48, 180, 12, 11, 0, 12, 0);
        send(0, 48, 180, 12, 7, 0, 8, 0);
        send(0, 7, 7, 7, 1, 0, 2, 0);
        send(1, 8, 8, 8, 1, 0, 2, 0);
        send(1, 16, 4, 4, 5, 0, 6, 0);
        send(0, 0, 25, 25, 0, 0, 1, 0);
        send(0, 0, 0, 0, 0, 1, 1, 0);
        send(1, 0, 25, 25, 0, 0, 1, 0);
        send(1, 0, 0, 0, 0, 1, 1, 0);
        send(0, 12, 18, 6, 3, 0, 4, 1);

        a_i[0] = 16'hFFFF;
        b_i[0] = 16'h0001;
        iv[0]  = 1'b1;
        tick();
        iv[0] = 1'b0;
        repeat (100) tick();
        check("calc_busy", 0, 32'(ir[0]), 0);
        rst = 1'b1;
        #1;
        check("abort_in_ready", 0, 32'(ir[0]), 1);
        check("abort_out_valid", 0, 32'(ov[0]), 0);
        check("abort_cycles", 0, 32'(c0), 0);
        check("abort_gcd", 0, 32'(g0), 0);
        tick();
        rst = 1'b0;
        tick();
        send(0, 9, 6, 3, 3, 0, 4, 0);
        send(1, 9, 6, 3, 4, 0, 5, 0);

        send(2, 255, 1, 1, 15, 0, 256, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
